// File: rtl/pool_2x2_stream_pkg.sv
// Shared constants and helpers for the S2 2x2 max-pooling stage.
package pool_2x2_stream_pkg;

    localparam int unsigned C1_SIZE = 28;
    localparam int unsigned S2_SIZE = C1_SIZE / 2;
    localparam int unsigned C1_MAPS = 6;
    localparam int unsigned DATA_W  = 32;

    // LSB of map k inside a packed multi-map bus; map k spans [lsb +: w].
    function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One feature map of the 2x2 max pool: horizontal pair hold register,
// half-width line buffer for even-row pair maxima and the output register.
module pool_lane
    import pool_2x2_stream_pkg::*;
#(
    parameter int unsigned IN_SIZE   = C1_SIZE,
    parameter int unsigned BIT_WIDTH = DATA_W,
    parameter int unsigned AW        = $clog2(IN_SIZE / 2)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        beat,
    input  logic                        col_odd,
    input  logic                        row_odd,
    input  logic [AW-1:0]               addr,
    input  logic signed [BIT_WIDTH-1:0] din,
    output logic signed [BIT_WIDTH-1:0] dout
);

    localparam int unsigned HALF = IN_SIZE / 2;

    logic signed [BIT_WIDTH-1:0] hold_q;
    logic signed [BIT_WIDTH-1:0] out_q;
    logic signed [BIT_WIDTH-1:0] linebuf_q [HALF];
    logic signed [BIT_WIDTH-1:0] pair;
    logic signed [BIT_WIDTH-1:0] lb_rd;
    logic signed [BIT_WIDTH-1:0] win_max;

    // Horizontal max of the current pair, then vertical max against the stored row above.
    always_comb begin
        pair    = (din > hold_q) ? din : hold_q;
        lb_rd   = linebuf_q[addr];
        win_max = (lb_rd > pair) ? lb_rd : pair;
    end

    // Capture the left pixel of each horizontal pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (beat && !col_odd) begin
            hold_q <= din;
        end
    end

    // Line buffer needs no reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (beat && col_odd && !row_odd) begin
            linebuf_q[addr] <= pair;
        end
    end

    // Register the 2x2 window maximum; holds between pooled beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (beat && col_odd && row_odd) begin
            out_q <= win_max;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/pool_2x2_stream.sv
// Streaming 2x2 stride-2 max pool over MAPS parallel feature maps in raster order.
module pool_2x2_stream
    import pool_2x2_stream_pkg::*;
#(
    parameter int unsigned IN_SIZE   = C1_SIZE,
    parameter int unsigned BIT_WIDTH = DATA_W,
    parameter int unsigned MAPS      = C1_MAPS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [BIT_WIDTH*MAPS-1:0]      in_data,
    output logic                           out_valid,
    output logic [BIT_WIDTH*MAPS-1:0]      out_data,
    output logic [$clog2(IN_SIZE/2)-1:0]   out_row,
    output logic [$clog2(IN_SIZE/2)-1:0]   out_col,
    output logic                           frame_done
);

    localparam int unsigned CW = $clog2(IN_SIZE);
    localparam int unsigned PW = $clog2(IN_SIZE / 2);

    logic [CW-1:0] col_q, row_q;
    logic [PW-1:0] out_row_q, out_col_q;
    logic          out_valid_q, frame_done_q;
    logic          col_last, row_last, fire;
    logic [PW-1:0] lb_addr;

    always_comb begin
        col_last = (col_q == CW'(IN_SIZE - 1));
        row_last = (row_q == CW'(IN_SIZE - 1));
        fire     = in_valid && col_q[0] && row_q[0];
        lb_addr  = PW'(col_q >> 1);
    end

    // Raster position of the incoming beat; only valid beats advance it.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_valid) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Pooled-beat qualifiers and coordinates, one cycle after the closing (odd,odd) pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            out_valid_q  <= fire;
            frame_done_q <= fire && row_last && col_last;
            if (fire) begin
                out_row_q <= PW'(row_q >> 1);
                out_col_q <= lb_addr;
            end
        end
    end

    for (genvar k = 0; k < MAPS; k++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(k, BIT_WIDTH);

        pool_lane #(
            .IN_SIZE   (IN_SIZE),
            .BIT_WIDTH (BIT_WIDTH),
            .AW        (PW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .beat    (in_valid),
            .col_odd (col_q[0]),
            .row_odd (row_q[0]),
            .addr    (lb_addr),
            .din     (in_data[LSB +: BIT_WIDTH]),
            .dout    (out_data[LSB +: BIT_WIDTH])
        );
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;

endmodule

// File: tb/tb_pool_2x2_stream.sv
// Directed bench for pool_2x2_stream: scenario table, scoreboard of pooled
// beats, and spot-value table checked against the captured pooled frame.
module tb_pool_2x2_stream;
    import pool_2x2_stream_pkg::*;

    localparam int N = C1_SIZE;
    localparam int H = S2_SIZE;
    localparam int M = C1_MAPS;
    localparam int W = DATA_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [W*M-1:0]   in_data;
    logic             out_valid;
    logic [W*M-1:0]   out_data;
    logic [3:0]       out_row, out_col;
    logic             frame_done;

    pool_2x2_stream dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;       // 0 ramp, 1 signed window, 2 per-map offset ramp
        int frames;
        int bubble;     // percent of idle cycles
        int rst_after;  // beats before a reset pulse, -1 for none
        int exp_outs;
        int exp_fd;
    } scen_t;

    typedef struct {
        int     scen;
        int     k;
        int     i;
        int     j;
        longint val;
    } spot_t;

    typedef struct {
        logic [W*M-1:0] data;
        int             r;
        int             c;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out, n_fd;

    exp_t  exp_q[$];
    logic  drive_trig = 1'b0;
    logic  drive_last = 1'b0;
    logic signed [W-1:0] cap [M][H][H];

    scen_t scens[6];
    spot_t spots[16];

    task automatic chk(input string name, input logic [W*M-1:0] act, input logic [W*M-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic signed [W-1:0] pix(input int mode, input int k, input int r,
                                                 input int c, input int off);
        if (mode == 1) begin
            if (k == 2 && r == 0 && c == 0) return -5;
            if (k == 2 && r == 0 && c == 1) return -3;
            if (k == 2 && r == 1 && c == 0) return -9;
            if (k == 2 && r == 1 && c == 1) return -1;
            return -100;
        end
        return W'(off + ((mode == 2) ? k * 1000 : 0) + r * N + c);
    endfunction

    function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    function automatic logic [W*M-1:0] beat(input int mode, input int r, input int c, input int off);
        logic [W*M-1:0] d;
        for (int k = 0; k < M; k++) d[k*W +: W] = pix(mode, k, r, c, off);
        return d;
    endfunction

    function automatic logic [W*M-1:0] pooled(input int mode, input int i, input int j,
                                               input int off);
        logic [W*M-1:0] d;
        for (int k = 0; k < M; k++) begin
            d[k*W +: W] = smax(smax(pix(mode, k, 2*i, 2*j, off), pix(mode, k, 2*i, 2*j+1, off)),
                               smax(pix(mode, k, 2*i+1, 2*j, off), pix(mode, k, 2*i+1, 2*j+1, off)));
        end
        return d;
    endfunction

    // Drive one pixel at the falling edge, inserting optional bubbles first.
    task automatic drive_pixel(input int mode, input int r, input int c, input int off,
                               input int bubble);
        exp_t e;
        while (bubble > 0 && $urandom_range(99) < bubble) begin
            in_valid   = 1'b0;
            drive_trig = 1'b0;
            drive_last = 1'b0;
            @(negedge clk);
        end
        in_valid   = 1'b1;
        in_data    = beat(mode, r, c, off);
        drive_trig = (r % 2 == 1) && (c % 2 == 1);
        drive_last = (r == N - 1) && (c == N - 1);
        if (drive_trig) begin
            e.data = pooled(mode, r / 2, c / 2, off);
            e.r    = r / 2;
            e.c    = c / 2;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid   = 1'b0;
        drive_trig = 1'b0;
        drive_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every cycle, out_valid/frame_done must follow the beat sampled one edge earlier.
    initial begin
        logic           trig, last, was_rst;
        logic [W*M-1:0] hold_data = '0;
        logic [3:0]     hold_row  = '0;
        logic [3:0]     hold_col  = '0;
        exp_t           e;
        forever begin
            @(posedge clk);
            trig    = drive_trig && in_valid && !rst;
            last    = drive_last;
            was_rst = rst;
            #1;
            chk("out_valid", out_valid, trig);
            chk("frame_done", frame_done, trig && last);
            if (frame_done) n_fd++;
            if (was_rst) begin
                hold_data = '0;
                hold_row  = '0;
                hold_col  = '0;
            end
            if (out_valid) begin
                n_out++;
                chk("scoreboard_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_row", out_row, e.r);
                    chk("out_col", out_col, e.c);
                    for (int k = 0; k < M; k++) cap[k][e.r][e.c] = out_data[k*W +: W];
                end
                hold_data = out_data;
                hold_row  = out_row;
                hold_col  = out_col;
            end else begin
                chk("hold_data", out_data, hold_data);
                chk("hold_row", out_row, hold_row);
                chk("hold_col", out_col, hold_col);
            end
        end
    end

    initial begin
        //           mode frames bubble rst_after outs fd
        scens[0] = '{0, 1,  0, -1, 196, 1};
        scens[1] = '{1, 1,  0, -1, 196, 1};
        scens[2] = '{2, 1,  0, -1, 196, 1};
        scens[3] = '{0, 1, 40, -1, 196, 1};
        scens[4] = '{0, 2,  0, -1, 392, 2};
        scens[5] = '{0, 1,  0, 300, 196, 1};

        spots[0]  = '{0, 0,  0,  0,   29};
        spots[1]  = '{0, 5, 13, 13,  783};
        spots[2]  = '{0, 3,  6,  7,  379};
        spots[3]  = '{1, 2,  0,  0,   -1};
        spots[4]  = '{1, 0,  0,  0, -100};
        spots[5]  = '{1, 2,  0,  1, -100};
        spots[6]  = '{1, 2, 13, 13, -100};
        spots[7]  = '{2, 0, 13, 13,  783};
        spots[8]  = '{2, 5, 13, 13, 5783};
        spots[9]  = '{2, 3,  0,  0, 3029};
        spots[10] = '{3, 1,  7,  3,  427};
        spots[11] = '{3, 4, 13, 13,  783};
        spots[12] = '{4, 0,  0,  0, 10029};
        spots[13] = '{4, 4, 13, 13, 10783};
        spots[14] = '{5, 2,  0,  0,   29};
        spots[15] = '{5, 0, 13, 13,  783};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 6; s++) begin
            n_out = 0;
            n_fd  = 0;
            if (scens[s].rst_after >= 0) begin
                for (int b = 0; b < scens[s].rst_after; b++)
                    drive_pixel(scens[s].mode, b / N, b % N, 0, 0);
                // rst wins over a simultaneous valid beat
                rst        = 1'b1;
                in_valid   = 1'b1;
                in_data    = beat(0, 5, 5, 0);
                drive_trig = 1'b0;
                drive_last = 1'b0;
                @(negedge clk);
                rst   = 1'b0;
                n_out = 0;
                n_fd  = 0;
                chk("scoreboard_drained_at_reset", exp_q.size(), 0);
                exp_q.delete();
            end
            for (int f = 0; f < scens[s].frames; f++)
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        drive_pixel(scens[s].mode, r, c, f * 10000, scens[s].bubble);
            idle(3);
            chk("out_count", n_out, scens[s].exp_outs);
            chk("frame_done_count", n_fd, scens[s].exp_fd);
            chk("scoreboard_drained", exp_q.size(), 0);
            exp_q.delete();
            for (int p = 0; p < 16; p++) begin
                if (spots[p].scen == s)
                    chk($sformatf("spot_s%0d_m%0d_%0d_%0d", s, spots[p].k, spots[p].i, spots[p].j),
                        cap[spots[p].k][spots[p].i][spots[p].j], spots[p].val);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
